// File: rtl/multdiv_ctrl_if.sv
// Issue/result bundle between the EX stage and the HI/LO multiply/divide sequencer.
// Handshake: start is a one-cycle strobe qualifying md_op/rs_data/rt_data; it is
// only honoured while busy is low. There is no ready; busy is the sole back-pressure.
interface multdiv_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_run;

  modport master (
    output start, md_op, rs_data, rt_data,
    input  busy, hi, lo, dbg_run
  );

  modport slave (
    input  start, md_op, rs_data, rt_data,
    output busy, hi, lo, dbg_run
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// HI/LO multiply/divide sequencer: latches the result at issue, counts down a fixed
// latency, then commits to the architectural HI/LO registers.
module multdiv_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  multdiv_ctrl_if.slave md
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [7:0] MULT_CNT = 8'(MULT_LAT);
  localparam logic [7:0] DIV_CNT  = 8'(DIV_LAT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_valid_q, pend_valid_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot, rem;
  logic               issue;

  always_comb begin
    prod_s = $signed({{32{md.rs_data[31]}}, md.rs_data}) *
             $signed({{32{md.rt_data[31]}}, md.rt_data});
    prod_u = {32'b0, md.rs_data} * {32'b0, md.rt_data};
    quot   = 32'b0;
    rem    = 32'b0;
    // The signed overflow case is pinned explicitly rather than left to the divider.
    if (md.rt_data != 32'b0) begin
      if (md.md_op == OP_DIV) begin
        if (md.rs_data == 32'h8000_0000 && md.rt_data == 32'hFFFF_FFFF) begin
          quot = 32'h8000_0000;
          rem  = 32'b0;
        end else begin
          quot = $unsigned($signed(md.rs_data) / $signed(md.rt_data));
          rem  = $unsigned($signed(md.rs_data) % $signed(md.rt_data));
        end
      end else begin
        quot = md.rs_data / md.rt_data;
        rem  = md.rs_data % md.rt_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    issue        = md.start && (state_q == IDLE) &&
                   (md.md_op >= OP_MULT) && (md.md_op <= OP_MTLO);

    case (state_q)
      IDLE: begin
        if (issue) begin
          case (md.md_op)
            OP_MULT: begin
              pend_hi_d    = prod_s[63:32];
              pend_lo_d    = prod_s[31:0];
              pend_valid_d = 1'b1;
              cnt_d        = MULT_CNT;
              state_d      = RUN;
            end
            OP_MULTU: begin
              pend_hi_d    = prod_u[63:32];
              pend_lo_d    = prod_u[31:0];
              pend_valid_d = 1'b1;
              cnt_d        = MULT_CNT;
              state_d      = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still occupies the unit but never commits.
              pend_hi_d    = rem;
              pend_lo_d    = quot;
              pend_valid_d = (md.rt_data != 32'b0);
              cnt_d        = DIV_CNT;
              state_d      = RUN;
            end
            OP_MTHI: hi_d = md.rs_data;
            OP_MTLO: lo_d = md.rs_data;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          if (pend_valid_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      hi_q         <= 32'b0;
      lo_q         <= 32'b0;
      pend_hi_q    <= 32'b0;
      pend_lo_q    <= 32'b0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // The combinational term covers the issue cycle, while the next multdiv op sits in ID.
  assign md.busy = (md.start && (state_q == IDLE) &&
                    (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU)) ||
                   (cnt_q != 8'd0);
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;
  assign md.dbg_run = (state_q == RUN);
endmodule
